// File: rtl/program_loader.sv
// program_loader: framed byte-stream loader that fills program memory and releases the core on a good checksum
module program_loader #(
  parameter int          MEMORY_DEPTH = 64,
  parameter int          ADDR_WIDTH   = 6,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  prog_we,
  output logic [ADDR_WIDTH-1:0] prog_addr,
  output logic [31:0]           prog_data,
  output logic                  cpu_hold,
  output logic                  done,
  output logic                  error
);
  typedef enum logic [2:0] {IDLE, LEN_HI, LEN_LO, DATA, WRITE, CHECK, DONE, ERROR} state_t;
  state_t                state_q, state_d;
  logic [15:0]           len_q, len_d;
  logic [23:0]           word_q, word_d;
  logic [1:0]            cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           data_q, data_d;
  logic [7:0]            chk_q, chk_d;
  logic                  acc;
  logic [15:0]           len_new;
  assign acc       = in_valid & in_ready;
  assign len_new   = {len_q[15:8], in_data};
  assign in_ready  = state_q != WRITE;
  assign prog_we   = state_q == WRITE;
  assign cpu_hold  = state_q != DONE;
  assign done      = state_q == DONE;
  assign error     = state_q == ERROR;
  assign prog_addr = addr_q;
  assign prog_data = data_q;
  // next-state: frame parsing, word assembly and checksum accumulation
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    word_d  = word_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    data_d  = data_q;
    chk_d   = chk_q;
    case (state_q)
      IDLE:   state_d = (acc && in_data == SYNC_BYTE) ? LEN_HI : IDLE;
      LEN_HI: if (acc) begin
        len_d[15:8] = in_data;
        state_d     = LEN_LO;
      end
      LEN_LO: if (acc) begin
        len_d[7:0] = in_data;
        idx_d      = '0;
        cnt_d      = '0;
        chk_d      = '0;
        state_d    = (len_new == 16'd0 || len_new > 16'(MEMORY_DEPTH)) ? ERROR : DATA;
      end
      DATA: if (acc) begin
        word_d = {word_q[15:0], in_data};
        chk_d  = chk_q ^ in_data;
        cnt_d  = cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          addr_d  = idx_q;
          data_d  = {word_q, in_data};
          state_d = WRITE;
        end
      end
      WRITE: begin
        idx_d   = idx_q + 1'b1;
        state_d = (16'(idx_q) + 16'd1 == len_q) ? CHECK : DATA;
      end
      CHECK:  if (acc) state_d = (in_data == chk_q) ? DONE : ERROR;
      DONE, ERROR: if (acc && in_data == SYNC_BYTE) state_d = LEN_HI;
      default: state_d = IDLE;
    endcase
  end
  // state and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      len_q   <= '0;
      word_q  <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      chk_q   <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      word_q  <= word_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      chk_q   <= chk_d;
    end
  end
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: scoreboard bench for the program loader
module tb_program_loader;
  logic        clk = 0;
  logic        reset = 1;
  logic [7:0]  in_data = 0;
  logic        in_valid = 0;
  logic        in_ready, prog_we, cpu_hold, done, error;
  logic [5:0]  prog_addr;
  logic [31:0] prog_data;
  typedef struct { logic [5:0] a; logic [31:0] d; int c; } wr_t;
  typedef struct { bit err; int c; } st_t;
  wr_t         wexp[$];
  st_t         sexp[$];
  logic [31:0] words[$];
  int          n_cmp = 0, n_bad = 0, cyc = 0, last_cyc = 0;
  logic        pd = 0, pe = 0;
  program_loader dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .cpu_hold(cpu_hold), .done(done), .error(error)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish, required finish");
    $fatal(1);
  end
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask
  // monitor: pops expected writes/status events whenever the DUT presents them
  always @(negedge clk) begin
    wr_t w;
    st_t s;
    check("in_ready_vs_we", in_ready, !prog_we);
    if (prog_we) begin
      if (wexp.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_write: got addr %0h data %0h, required no write", prog_addr, prog_data);
      end else begin
        w = wexp.pop_front();
        check("write_addr", prog_addr, w.a);
        check("write_data", prog_data, w.d);
        check("write_cycle", cyc, w.c);
      end
    end
    if ((done && !pd) || (error && !pe)) begin
      if (sexp.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_status: got done %0b error %0b, required none", done, error);
      end else begin
        s = sexp.pop_front();
        check("status_error", error, s.err);
        check("status_done", done, !s.err);
        check("status_cpu_hold", cpu_hold, s.err);
        check("status_cycle", cyc, s.c);
      end
    end
    pd <= done;
    pe <= error;
  end
  task automatic send(input logic [7:0] b, input bit gap);
    int n = 0;
    if (gap) begin
      in_valid = 0;
      @(posedge clk); #1;
    end
    in_data = b;
    in_valid = 1;
    while (!in_ready && n < 16) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      n_cmp++; n_bad++;
      $display("FAIL ready_timeout: in_ready got 0, required 1");
    end
    @(posedge clk); #1;
    in_valid = 0;
    last_cyc = cyc;
  endtask
  task automatic send_word(input int i, input bit gap);
    for (int k = 3; k >= 0; k--) send(words[i][8*k +: 8], gap);
    wexp.push_back('{6'(i), words[i], last_cyc});
  endtask
  task automatic load(input bit bad, input bit gap, input bit sync);
    logic [7:0] c = 0;
    if (sync) send(8'hA5, gap);
    send(8'(words.size() >> 8), gap);
    send(8'(words.size()), gap);
    foreach (words[i]) begin
      send_word(i, gap);
      c = c ^ words[i][31:24] ^ words[i][23:16] ^ words[i][15:8] ^ words[i][7:0];
    end
    send(bad ? c ^ 8'h01 : c, gap);
    sexp.push_back('{bad, last_cyc});
  endtask
  task automatic bad_len(input logic [7:0] hi, input logic [7:0] lo);
    send(8'hA5, 0);
    send(hi, 0);
    send(lo, 0);
    sexp.push_back('{1'b1, last_cyc});
  endtask
  task automatic check_done(input string nm);
    check({nm, "_done"}, done, 1);
    check({nm, "_cpu_hold"}, cpu_hold, 0);
    check({nm, "_error"}, error, 0);
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_prog_we", prog_we, 0);
    check("rst_prog_addr", prog_addr, 0);
    check("rst_prog_data", prog_data, 0);
    check("rst_cpu_hold", cpu_hold, 1);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    reset = 0;
    words = '{32'h20080005, 32'h2009000A};
    load(0, 0, 1);
    check_done("normal");
    send(8'hA5, 0);
    check("reload1_cpu_hold", cpu_hold, 1);
    check("reload1_done", done, 0);
    load(1, 0, 0);
    check("badchk_error", error, 1);
    check("badchk_cpu_hold", cpu_hold, 1);
    check("badchk_done", done, 0);
    bad_len(8'h00, 8'h00);
    bad_len(8'h00, 8'h41);
    check("len41_error", error, 1);
    words = {};
    for (int i = 0; i < 64; i++) words.push_back((32'h01020304 * 32'(i)) ^ 32'hDEADBEEF);
    load(0, 0, 1);
    check_done("full64");
    send(8'h00, 1);
    send(8'hFF, 1);
    send(8'h5A, 1);
    check_done("junk_ignored");
    words = '{32'h3C1D0040};
    load(0, 1, 1);
    check_done("gapped");
    send(8'hA5, 0);
    check("reload2_cpu_hold", cpu_hold, 1);
    check("reload2_done", done, 0);
    words = '{32'h8C080000, 32'hAC090004};
    load(0, 0, 0);
    check_done("reload2");
    words = '{32'h11223344, 32'h55667788};
    send(8'hA5, 0);
    send(8'h00, 0);
    send(8'h02, 0);
    send_word(0, 0);
    send(8'h55, 0);
    send(8'h66, 0);
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    check("midrst_cpu_hold", cpu_hold, 1);
    check("midrst_done", done, 0);
    check("midrst_error", error, 0);
    check("midrst_in_ready", in_ready, 1);
    check("midrst_prog_we", prog_we, 0);
    words = '{32'hCAFEF00D, 32'h0BADBEEF};
    load(0, 0, 1);
    check_done("after_reset");
    repeat (3) @(posedge clk);
    #1;
    check("pending_writes", wexp.size(), 0);
    check("pending_status", sexp.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
